// File: rtl/parking_controller.sv
// Parking-garage occupancy controller: per-floor counters, lowest-free-floor
// assignment, and an entry-gate FSM that holds the barrier open for GATE_HOLD cycles.
module parking_controller #(
  parameter int NUM_FLOORS = 2,
  parameter int FLOOR_CAP  = 500,
  parameter int CNT_W      = 32,
  parameter int GATE_HOLD  = 4,
  localparam int FLR_W     = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IN,
  input  logic [NUM_FLOORS-1:0] OUT,
  output logic [CNT_W-1:0]      CARS,
  output logic [CNT_W-1:0]      AVAILABLE,
  output logic                  FULL,
  output logic [NUM_FLOORS-1:0] FLOOR_FREE,
  output logic                  ASSIGN_VALID,
  output logic [FLR_W-1:0]      ASSIGN_FLOOR,
  output logic                  REJECT,
  output logic                  GATE_OPEN,
  output logic                  BUSY
);

  localparam int CW = $clog2(FLOOR_CAP + 1);
  localparam int HW = $clog2(GATE_HOLD + 1);
  localparam logic [CNT_W-1:0] TOTAL     = CNT_W'(NUM_FLOORS * FLOOR_CAP);
  localparam logic [CW-1:0]    CAP       = CW'(FLOOR_CAP);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(GATE_HOLD - 1);

  typedef enum logic {IDLE, OPEN} gateState_e;

  gateState_e             state_q;
  logic [HW-1:0]          holdCnt_q;
  logic [CW-1:0]          cnt_q [NUM_FLOORS];
  logic [CW-1:0]          cnt_d [NUM_FLOORS];
  logic [NUM_FLOORS-1:0]  freeNow;
  logic [NUM_FLOORS-1:0]  free_d;
  logic [FLR_W-1:0]       sel;
  logic                   anyFree;
  logic                   request;
  logic                   admit;
  logic [CNT_W-1:0]       cars_d;

  // Floor choice looks only at pre-exit counts, so a floor freed this cycle
  // cannot be handed out until the next one.
  always_comb begin
    freeNow = '0;
    anyFree = 1'b0;
    sel     = '0;
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      freeNow[f] = (cnt_q[f] < CAP);
      if (freeNow[f]) begin
        anyFree = 1'b1;
        sel     = FLR_W'(f);
      end
    end
    request = (state_q == IDLE) && IN;
    admit   = request && anyFree;
  end

  always_comb begin
    cars_d = '0;
    free_d = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      cnt_d[f] = cnt_q[f];
      if (admit && (sel == FLR_W'(f))) cnt_d[f] = cnt_d[f] + CW'(1);
      if (OUT[f] && (cnt_q[f] != '0))  cnt_d[f] = cnt_d[f] - CW'(1);
      free_d[f] = (cnt_d[f] < CAP);
      cars_d    = cars_d + CNT_W'(cnt_d[f]);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int f = 0; f < NUM_FLOORS; f++) cnt_q[f] <= '0;
      state_q      <= IDLE;
      holdCnt_q    <= '0;
      CARS         <= '0;
      AVAILABLE    <= TOTAL;
      FULL         <= 1'b0;
      FLOOR_FREE   <= '1;
      ASSIGN_VALID <= 1'b0;
      ASSIGN_FLOOR <= '0;
      REJECT       <= 1'b0;
      GATE_OPEN    <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      for (int f = 0; f < NUM_FLOORS; f++) cnt_q[f] <= cnt_d[f];
      CARS         <= cars_d;
      AVAILABLE    <= TOTAL - cars_d;
      FULL         <= (cars_d == TOTAL);
      FLOOR_FREE   <= free_d;
      ASSIGN_VALID <= admit;
      REJECT       <= request && !anyFree;
      if (admit) ASSIGN_FLOOR <= sel;
      // Gate stays open for GATE_HOLD edges after the admitting edge.
      case (state_q)
        IDLE: begin
          if (admit) begin
            state_q   <= OPEN;
            holdCnt_q <= '0;
            GATE_OPEN <= 1'b1;
            BUSY      <= 1'b1;
          end
        end
        OPEN: begin
          if (holdCnt_q == HOLD_LAST) begin
            state_q   <= IDLE;
            GATE_OPEN <= 1'b0;
            BUSY      <= 1'b0;
          end else begin
            holdCnt_q <= holdCnt_q + HW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_controller.sv
// Scoreboard bench for parking_controller: a floor-count reference model feeds an
// expectation queue that a negedge monitor drains; a small 3-floor instance checks corner cases.
module tb_parking_controller;

  localparam int NF    = 2;
  localparam int CAP   = 500;
  localparam int GH    = 4;
  localparam int TOTAL = NF * CAP;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          inReq = 1'b0;
  logic [NF-1:0] outReq = '0;
  logic [31:0]   cars, avail;
  logic          full, assignValid, reject, gateOpen, busy;
  logic [NF-1:0] floorFree;
  logic [0:0]    assignFloor;

  logic       sRstN = 1'b0;
  logic       sIn = 1'b0;
  logic [2:0] sOut = '0;
  logic [7:0] sCars, sAvail;
  logic       sFull, sAv, sRej, sGate, sBusy;
  logic [2:0] sFree;
  logic [1:0] sFl;

  always #5 clk = ~clk;

  parking_controller #(.NUM_FLOORS(NF), .FLOOR_CAP(CAP), .CNT_W(32), .GATE_HOLD(GH)) dut (
    .CLK(clk), .RST_N(rstN), .IN(inReq), .OUT(outReq),
    .CARS(cars), .AVAILABLE(avail), .FULL(full), .FLOOR_FREE(floorFree),
    .ASSIGN_VALID(assignValid), .ASSIGN_FLOOR(assignFloor), .REJECT(reject),
    .GATE_OPEN(gateOpen), .BUSY(busy)
  );

  parking_controller #(.NUM_FLOORS(3), .FLOOR_CAP(2), .CNT_W(8), .GATE_HOLD(2)) dutSmall (
    .CLK(clk), .RST_N(sRstN), .IN(sIn), .OUT(sOut),
    .CARS(sCars), .AVAILABLE(sAvail), .FULL(sFull), .FLOOR_FREE(sFree),
    .ASSIGN_VALID(sAv), .ASSIGN_FLOOR(sFl), .REJECT(sRej),
    .GATE_OPEN(sGate), .BUSY(sBusy)
  );

  typedef struct {
    int          edgeNo;
    int          cars;
    int          avail;
    bit          full;
    logic [NF-1:0] ffree;
    bit          av;
    int          fl;
    bit          rej;
    bit          gate;
  } exp_t;

  exp_t sbQ[$];
  exp_t mon;
  int   edgeCount = 0;
  int   errors = 0;
  int   checks = 0;
  int   mCnt[NF];
  int   mGate = 0;

  always @(posedge clk) edgeCount++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  function automatic int modelCars();
    int s = 0;
    for (int f = 0; f < NF; f++) s += mCnt[f];
    return s;
  endfunction

  // Reference model: plain per-floor occupancy plus a remaining-open-cycles timer.
  task automatic applyStimulus(input bit rst, input bit inV, input logic [NF-1:0] outV);
    exp_t e;
    int   firstFree;
    @(negedge clk);
    rstN   = !rst;
    inReq  = inV;
    outReq = outV;
    e.av  = 1'b0;
    e.rej = 1'b0;
    e.fl  = 0;
    if (rst) begin
      for (int f = 0; f < NF; f++) mCnt[f] = 0;
      mGate = 0;
    end else begin
      firstFree = -1;
      for (int f = 0; f < NF; f++)
        if (mCnt[f] < CAP && firstFree < 0) firstFree = f;
      if (mGate > 0) mGate--;
      else if (inV) begin
        if (firstFree >= 0) begin
          e.av = 1'b1;
          e.fl = firstFree;
        end else e.rej = 1'b1;
      end
      for (int f = 0; f < NF; f++)
        if (outV[f] && mCnt[f] > 0) mCnt[f]--;
      if (e.av) begin
        mCnt[firstFree]++;
        mGate = GH;
      end
    end
    e.edgeNo = edgeCount + 1;
    e.cars   = modelCars();
    e.avail  = TOTAL - e.cars;
    e.full   = (e.cars == TOTAL);
    for (int f = 0; f < NF; f++) e.ffree[f] = (mCnt[f] < CAP);
    e.gate   = (mGate > 0);
    sbQ.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sbQ.size() > 0 && sbQ[0].edgeNo <= edgeCount) begin
      mon = sbQ.pop_front();
      checkOutput("CARS", int'(cars), mon.cars);
      checkOutput("AVAILABLE", int'(avail), mon.avail);
      checkOutput("FULL", int'(full), int'(mon.full));
      checkOutput("FLOOR_FREE", int'(floorFree), int'(mon.ffree));
      checkOutput("ASSIGN_VALID", int'(assignValid), int'(mon.av));
      if (mon.av) checkOutput("ASSIGN_FLOOR", int'(assignFloor), mon.fl);
      checkOutput("REJECT", int'(reject), int'(mon.rej));
      checkOutput("GATE_OPEN", int'(gateOpen), int'(mon.gate));
      checkOutput("BUSY", int'(busy), int'(mon.gate));
    end
  end

  task automatic admitOne();
    applyStimulus(1'b0, 1'b1, '0);
    repeat (GH) applyStimulus(1'b0, 1'b0, '0);
  endtask

  initial begin
    int guard;
    logic [NF-1:0] rOut;

    repeat (2) applyStimulus(1'b1, 1'b0, '0);

    // First admission, then IN held through the whole open window is ignored.
    applyStimulus(1'b0, 1'b1, '0);
    repeat (GH) applyStimulus(1'b0, 1'b1, '0);
    repeat (2) applyStimulus(1'b0, 1'b0, '0);

    // Floor 0 at 3, floor 1 empty: a double exit only removes one car.
    repeat (2) admitOne();
    applyStimulus(1'b0, 1'b0, 2'b11);

    // Build to 7 cars and reset in the second open cycle.
    repeat (4) admitOne();
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);

    guard = 0;
    while (modelCars() < TOTAL && guard < 20000) begin
      applyStimulus(1'b0, 1'b1, '0);
      guard++;
    end
    checkOutput("fill reached capacity", modelCars(), TOTAL);
    repeat (8) applyStimulus(1'b0, 1'b1, '0);

    // Full garage: exit and entry in the same cycle still rejects.
    applyStimulus(1'b0, 1'b1, 2'b01);
    admitOne();

    repeat (3000) begin
      for (int f = 0; f < NF; f++) rOut[f] = ($urandom_range(0, 15) == 0);
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), rOut);
    end

    repeat (2) applyStimulus(1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", sbQ.size(), 0);

    // Three floors of two: fill, free floor 1, next car goes to floor 1.
    sRstN = 1'b0;
    @(negedge clk);
    sRstN = 1'b1;
    sIn   = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("small CARS full", int'(sCars), 6);
    checkOutput("small FULL", int'(sFull), 1);
    checkOutput("small FLOOR_FREE full", int'(sFree), 0);
    sIn  = 1'b0;
    sOut = 3'b010;
    @(negedge clk);
    checkOutput("small CARS after exit", int'(sCars), 5);
    checkOutput("small FLOOR_FREE after exit", int'(sFree), 2);
    sOut = '0;
    sIn  = 1'b1;
    @(negedge clk);
    sIn = 1'b0;
    checkOutput("small ASSIGN_VALID", int'(sAv), 1);
    checkOutput("small ASSIGN_FLOOR", int'(sFl), 1);
    checkOutput("small FULL refill", int'(sFull), 1);
    checkOutput("small CARS refill", int'(sCars), 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parking_controller.md
# parking_controller

Clocked, parametrised parking-garage occupancy controller for the gate/display subsystem. Tracks per-floor occupancy for `NUM_FLOORS` floors of `FLOOR_CAP` spaces each and assigns every admitted car to the lowest-index floor with space. Drives an entry-gate state machine and publishes total cars, free spaces, full status and per-floor availability. Exit events are accepted per floor and never underflow a counter.

## Interface
Parameters:
- `NUM_FLOORS`, default 2: number of floors; must be at least 1.
- `FLOOR_CAP`, default 500: spaces per floor; must be at least 1.
- `CNT_W`, default 32: width of the total counters; must hold `NUM_FLOORS*FLOOR_CAP`.
- `GATE_HOLD`, default 4: cycles the entry gate stays open; must be at least 1.
- Derived `FLR_W` = `$clog2(NUM_FLOORS)`, minimum 1.

Ports:
- `CLK`  in  1: single clock, rising edge.
- `RST_N`  in  1: synchronous, active-low reset.
- `IN`  in  1: entry request, level-sampled each cycle.
- `OUT`  in  `NUM_FLOORS`: exit strobe per floor; bit f means one car leaves floor f.
- `CARS`  out  `CNT_W`: total parked cars.
- `AVAILABLE`  out  `CNT_W`: equals `NUM_FLOORS*FLOOR_CAP - CARS`.
- `FULL`  out  1: high when `CARS` equals total capacity.
- `FLOOR_FREE`  out  `NUM_FLOORS`: bit f high when floor f count is below `FLOOR_CAP`.
- `ASSIGN_VALID`  out  1: one-cycle pulse when a car is admitted.
- `ASSIGN_FLOOR`  out  `FLR_W`: floor given to the admitted car; valid only with `ASSIGN_VALID`.
- `REJECT`  out  1: one-cycle pulse when a request meets a full garage.
- `GATE_OPEN`  out  1: entry barrier drive.
- `BUSY`  out  1: high while the gate FSM is not in IDLE.

## Operation
- Gate FSM, states IDLE and OPEN.
- In IDLE with `IN`=1 and at least one floor with `FLOOR_FREE`=1:
  - admit the car to the lowest such floor f;
  - increment floor f count;
  - pulse `ASSIGN_VALID` with `ASSIGN_FLOOR`=f;
  - go to OPEN.
- In IDLE with `IN`=1 and all floors full: pulse `REJECT`, stay in IDLE, change no counts.
- OPEN:
  - `GATE_OPEN`=1 for exactly `GATE_HOLD` cycles, then return to IDLE.
  - `IN` is ignored in OPEN; it is not queued.
- Exits: for every f with `OUT[f]`=1 and floor f count >0, decrement that count. If the count is 0, ignore the exit silently.
- All exit bits in one cycle are applied together. N valid exits reduce `CARS` by N.
- Simultaneous entry and exits:
  - All apply in the same cycle.
  - Floor selection uses the counts from before that cycle's exits, so a floor freed in the same cycle is not reused until the next cycle.
  - An entry and an exit on the same floor leave that floor's count unchanged.
- Width rules: floor counts are `$clog2(FLOOR_CAP+1)` bits. `CARS` is the sum of floor counts. Counts never exceed `FLOOR_CAP` or go below 0; no wrap-around.
- `FULL` = `CARS` equals `NUM_FLOORS*FLOOR_CAP`. `FLOOR_FREE` is the per-floor below-capacity compare.

## Timing
- Every output is registered and updates on the rising edge after the inputs are sampled.
- Admission path:
  - `IN` sampled high at edge k in IDLE.
  - `ASSIGN_VALID`, new `CARS`/`AVAILABLE`/`FULL`/`FLOOR_FREE`, and `GATE_OPEN`=1 are all visible after edge k.
  - `GATE_OPEN` stays high through edge k+`GATE_HOLD`.
  - The FSM is back in IDLE and accepts `IN` at edge k+`GATE_HOLD`+1.
  - `BUSY` follows `GATE_OPEN`.
- `REJECT` is visible the cycle after the request and lasts one cycle. A held-high `IN` in a full garage produces `REJECT` every cycle.
- An exit sampled at edge k is reflected in the counters after edge k: one-cycle latency.
- Reset values:
  - `CARS`=0, `AVAILABLE`=`NUM_FLOORS*FLOOR_CAP`, `FULL`=0;
  - `FLOOR_FREE`=all ones;
  - `ASSIGN_VALID`=0, `ASSIGN_FLOOR`=0, `REJECT`=0, `GATE_OPEN`=0, `BUSY`=0;
  - FSM in IDLE; all floor counts 0.
- Reset asserted mid-OPEN closes the gate and clears all counts at that edge. Reset has priority over `IN` and `OUT`.

## Test plan
- Reset, then one `IN` pulse (NUM_FLOORS=2, FLOOR_CAP=500, GATE_HOLD=4) -> next cycle `ASSIGN_VALID`=1, `ASSIGN_FLOOR`=0, `CARS`=1, `AVAILABLE`=999; `GATE_OPEN` high exactly 4 cycles; an `IN` during OPEN is ignored.
- 500 admissions -> `FLOOR_FREE`=2'b10. The 501st is assigned to floor 1. After 1000 admissions `FULL`=1 and `AVAILABLE`=0. A further `IN` -> `REJECT` pulse, `CARS` stays 1000, gate stays closed.
- `FULL` garage, `OUT`=2'b01 and `IN` in the same idle cycle -> `REJECT`, `CARS`=999. Next `IN` -> assigned floor 0, `CARS`=1000.
- `OUT`=2'b11 with floor 1 empty and floor 0 at 3 -> floor 0 becomes 2, floor 1 stays 0, `CARS` drops by 1 only.
- Reset asserted during cycle 2 of OPEN with `CARS`=7 -> after that edge `GATE_OPEN`=0, `CARS`=0, `AVAILABLE`=1000, FSM in IDLE.
- NUM_FLOORS=3, FLOOR_CAP=2: fill 6, exit floor 1, then `IN` -> `ASSIGN_FLOOR`=1, `FULL`=1.
